// File: rtl/negedge_sync_fifo.sv
// Single-clock byte FIFO for the FT2232H receive path.
// All state advances on the falling edge of clk_i, so the consumer can set up
// rdreq during the high phase. rdempty is exported directly as RXF#
// (high = no data). q is registered and updates one falling edge after the
// read is accepted; it is not show-ahead.
module negedge_sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    clear_n,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic                    wrreq,
  input  logic                    rdreq,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    rdempty,
  output logic                    wrfull,
  output logic [ADDRESS_WIDTH:0]  usedw
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDRESS_WIDTH:0] wr_ptr;
  logic [ADDRESS_WIDTH:0] rd_ptr;
  logic                   wr_en;
  logic                   rd_en;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bits means full.
  assign rdempty = (wr_ptr == rd_ptr);
  assign wrfull  = (wr_ptr[ADDRESS_WIDTH-1:0] == rd_ptr[ADDRESS_WIDTH-1:0]) &&
                   (wr_ptr[ADDRESS_WIDTH] != rd_ptr[ADDRESS_WIDTH]);
  assign usedw   = wr_ptr - rd_ptr;

  // Accepts use the pre-edge flags: a full FIFO rejects a simultaneous
  // write, an empty FIFO rejects a simultaneous read (no bypass).
  assign wr_en = wrreq & ~wrfull;
  assign rd_en = rdreq & ~rdempty;

  // Storage write; contents survive reset, clear only discards via pointers.
  always_ff @(negedge clk_i) begin
    if (clear_n && wr_en) begin
      mem[wr_ptr[ADDRESS_WIDTH-1:0]] <= data;
    end
  end

  // Pointer and read-data registers with synchronous active-low clear.
  always_ff @(negedge clk_i) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q      <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        q      <= mem[rd_ptr[ADDRESS_WIDTH-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_negedge_sync_fifo.sv
// Directed bench for negedge_sync_fifo: a vector table for reset, single-word
// and empty-FIFO corner cases, then hand sequences for fill/order, full-FIFO
// read+write, pointer wrap and mid-stream clear.
module tb_negedge_sync_fifo;

  logic       clk_i;
  logic       clear_n;
  logic [7:0] data;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] q;
  logic       rdempty;
  logic       wrfull;
  logic [4:0] usedw;

  int n_checks;
  int n_errors;

  negedge_sync_fifo #(
    .DATA_WIDTH   (8),
    .ADDRESS_WIDTH(4)
  ) dut (
    .clk_i  (clk_i),
    .clear_n(clear_n),
    .data   (data),
    .wrreq  (wrreq),
    .rdreq  (rdreq),
    .q      (q),
    .rdempty(rdempty),
    .wrfull (wrfull),
    .usedw  (usedw)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       clr_n;
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_empty;
    logic       exp_full;
    logic [4:0] exp_used;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, let one falling edge happen, then settle past it.
  task automatic apply(input logic c, input logic w, input logic r, input logic [7:0] d);
    clear_n = c;
    wrreq   = w;
    rdreq   = r;
    data    = d;
    @(negedge clk_i);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_n  = 1'b0;
    wrreq    = 1'b0;
    rdreq    = 1'b0;
    data     = 8'h00;

    //        clr  wr   rd   data    q      empty full used
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h00, 1'b1, 1'b0, 5'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h22, 8'h00, 1'b1, 1'b0, 5'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 5'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b0, 5'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b0, 5'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0, 5'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b0, 5'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h3C, 1'b0, 1'b0, 5'd1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h20, 8'h10, 1'b0, 1'b0, 5'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h55, 8'h10, 1'b0, 1'b0, 5'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h20, 1'b1, 1'b0, 5'd0};

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].clr_n, vecs[i].wr, vecs[i].rd, vecs[i].d);
      chk($sformatf("vec%0d_q", i),     q,       vecs[i].exp_q);
      chk($sformatf("vec%0d_empty", i), rdempty, vecs[i].exp_empty);
      chk($sformatf("vec%0d_full", i),  wrfull,  vecs[i].exp_full);
      chk($sformatf("vec%0d_usedw", i), usedw,   vecs[i].exp_used);
    end

    // Fill with 0x00..0x0F, then an ignored 17th write, then drain in order.
    for (int i = 0; i < 16; i++) apply(1'b1, 1'b1, 1'b0, 8'(i));
    chk("fill_full",  wrfull, 1);
    chk("fill_usedw", usedw,  16);
    apply(1'b1, 1'b1, 1'b0, 8'hFF);
    chk("over_full",  wrfull, 1);
    chk("over_usedw", usedw,  16);
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 1'b0, 1'b1, 8'h00);
      chk($sformatf("drain%0d_q", i), q, i);
    end
    chk("drain_empty", rdempty, 1);
    chk("drain_usedw", usedw,   0);

    // Full FIFO with simultaneous read+write: read wins, write rejected.
    for (int i = 0; i < 16; i++) apply(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
    chk("full2_full", wrfull, 1);
    apply(1'b1, 1'b1, 1'b1, 8'hEE);
    chk("fullrw_q",     q,      8'h40);
    chk("fullrw_usedw", usedw,  15);
    chk("fullrw_full",  wrfull, 0);
    for (int i = 1; i < 16; i++) begin
      apply(1'b1, 1'b0, 1'b1, 8'h00);
      chk($sformatf("fullrw_drain%0d_q", i), q, 8'h40 + i);
    end
    chk("fullrw_empty", rdempty, 1);

    // Pointer wrap: 40 write/read pairs, occupancy never above 1.
    for (int i = 0; i < 40; i++) begin
      apply(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
      chk($sformatf("wrap%0d_usedw_w", i), usedw, 1);
      apply(1'b1, 1'b0, 1'b1, 8'h00);
      chk($sformatf("wrap%0d_q", i), q, 8'h80 + i);
      chk($sformatf("wrap%0d_usedw_r", i), usedw, 0);
    end

    // Mid-stream clear discards stored words.
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
    chk("mid_usedw_pre", usedw, 5);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk("mid_usedw", usedw,   0);
    chk("mid_empty", rdempty, 1);
    chk("mid_q",     q,       0);
    apply(1'b1, 1'b1, 1'b0, 8'h77);
    chk("mid_w_usedw", usedw, 1);
    apply(1'b1, 1'b0, 1'b1, 8'h00);
    chk("mid_r_q",     q,       8'h77);
    chk("mid_r_empty", rdempty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/negedge_sync_fifo.md
Name: negedge_sync_fifo

Overview:
- Single-clock first-in first-out byte buffer for the USB FT2232H receive path.
- A producer pushes bytes in with wrreq; the consumer pops them with rdreq.
- rdempty is exported directly as the FT2232H RXF# status, so a high level means "no data available".
- All state advances on the falling edge of the clock, so the consumer can set up rdreq during the high phase.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDRESS_WIDTH, 4, log2 of the depth; DEPTH = 2**ADDRESS_WIDTH (16 by default).

Ports:
- clk_i  input  1  single clock; every register updates on its falling edge only.
- clear_n  input  1  synchronous active-low reset, sampled on the falling edge of clk_i.
- data  input  DATA_WIDTH  write data, sampled on the falling edge when a write is accepted.
- wrreq  input  1  write request.
- rdreq  input  1  read request.
- q  output  DATA_WIDTH  registered read data.
- rdempty  output  1  high when the FIFO holds 0 words.
- wrfull  output  1  high when the FIFO holds DEPTH words.
- usedw  output  ADDRESS_WIDTH+1  current number of stored words, 0..DEPTH.

Behaviour:
- Storage: DEPTH x DATA_WIDTH memory.
- Pointers: write and read pointers, each ADDRESS_WIDTH+1 bits wide.
  - The low ADDRESS_WIDTH bits index memory.
  - The MSB is the wrap flag; pointers wrap modulo 2*DEPTH.
- Flags:
  - empty when wr_ptr == rd_ptr.
  - full when the low bits are equal and the MSBs differ.
  - usedw = wr_ptr - rd_ptr (modulo 2*DEPTH).
- Reset, clear_n low at a falling edge:
  - both pointers cleared to 0 and q = 0.
  - rdempty = 1, wrfull = 0, usedw = 0.
  - Memory contents are not cleared.
  - Reset overrides any wrreq or rdreq on the same edge.
  - Reset mid-stream discards all stored data.
- Write accept = wrreq & ~wrfull, evaluated on the pre-edge state.
  - On accept: mem[wr_ptr] <= data; wr_ptr increments.
  - wrreq while full is ignored silently; no overwrite occurs.
- Read accept = rdreq & ~rdempty, evaluated on the pre-edge state.
  - On accept: q <= mem[rd_ptr]; rd_ptr increments.
  - Read latency is one falling edge: q is valid after the edge that accepted the read (not show-ahead).
  - rdreq while empty is ignored; q holds its previous value.
  - q also holds its value on every edge with no accepted read.
- Simultaneous accepted read and write:
  - both happen on the same edge; usedw is unchanged.
  - When full: the read is accepted, the write is rejected (the full flag is evaluated pre-edge), and usedw drops by 1.
  - When empty: the write is accepted, the read is rejected (no bypass), and usedw becomes 1.
- Flag and usedw timing: rdempty, wrfull and usedw are combinational from the registered pointers, so they update right after the falling edge that changes the pointers.
- Edge sensitivity: nothing happens on the rising edge of clk_i; inputs only need to be stable around the falling edge.

Test Plan:
- Reset: hold clear_n=0 for 2 falling edges with wrreq=rdreq=1 -> rdempty=1, wrfull=0, usedw=0, q=8'h00.
- Single word: write 8'hA5 on one edge, then assert rdreq for one edge -> rdempty falls after the write edge; q=8'hA5 after the read edge; rdempty=1 and usedw=0 afterwards.
- Fill and order: write 8'h00..8'h0F (16 words) -> wrfull=1 and usedw=16.
  - A 17th write of 8'hFF is ignored.
  - 16 reads return 8'h00..8'h0F in order; the final state is rdempty=1.
- Pointer wrap: do 40 interleaved write/read pairs with incrementing data -> read data matches written data in order across multiple pointer wraps; usedw never exceeds 1.
- Boundaries:
  - rdreq on an empty FIFO with wrreq=1, data=8'h3C -> q unchanged, usedw=1; the next read gives 8'h3C.
  - On a full FIFO, rdreq+wrreq -> usedw=15, and the new data is not stored.
- Reset mid-operation: store 5 words, then pulse clear_n low for one edge -> usedw=0, rdempty=1; a subsequent write/read of 8'h77 returns 8'h77.
